// File: rtl/add_sub.sv
// Registered WIDTH-bit two's-complement adder/subtractor built from an explicit
// ripple of full-adder cells; results and status flags appear one cycle after in_valid.
module add_sub #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   output logic             out_valid,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             OVF,
   output logic             ZERO
);

   logic [WIDTH-1:0] sum;
   logic             carry_msb_in;
   logic             carry_msb_out;

   // Each cell owns its carry nets so the chain is a plain netlist, not a self-referencing vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic b_eff;
      logic c_in;
      logic c_out;

      assign b_eff = B[i] ^ SUB;
      if (i == 0) begin : g_first
         assign c_in = SUB;
      end else begin : g_next
         assign c_in = g_fa[i-1].c_out;
      end
      assign sum[i] = A[i] ^ b_eff ^ c_in;
      assign c_out  = (A[i] & b_eff) | (c_in & (A[i] ^ b_eff));
   end

   assign carry_msb_in  = g_fa[WIDTH-1].c_in;
   assign carry_msb_out = g_fa[WIDTH-1].c_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         S         <= '0;
         COUT      <= 1'b0;
         OVF       <= 1'b0;
         ZERO      <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // Results only load on valid input, so idle-cycle operands never reach the outputs.
         if (in_valid) begin
            S    <= sum;
            COUT <= carry_msb_out;
            OVF  <= carry_msb_out ^ carry_msb_in;
            ZERO <= (sum == '0);
         end
      end
   end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_add_sub;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             SUB;
   logic             out_valid;
   logic [WIDTH-1:0] S;
   logic             COUT;
   logic             OVF;
   logic             ZERO;

   int checks = 0;
   int passed = 0;

   add_sub #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .SUB      (SUB),
      .out_valid(out_valid),
      .S        (S),
      .COUT     (COUT),
      .OVF      (OVF),
      .ZERO     (ZERO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             cout;
      logic             ovf;
      logic             zero;
      logic [WIDTH-1:0] s;
   } res_t;

   // Plain integer arithmetic: unsigned compare for carry, signed range test for overflow.
   function automatic res_t model(input int a, input int b, input bit sub);
      res_t r;
      int   full;
      int   sa;
      int   sb;
      int   sres;
      full  = 1 << WIDTH;
      r.s   = WIDTH'(sub ? (a - b + full) % full : (a + b) % full);
      r.cout = sub ? (a >= b) : (a + b >= full);
      sa    = (a >= full / 2) ? a - full : a;
      sb    = (b >= full / 2) ? b - full : b;
      sres  = sub ? sa - sb : sa + sb;
      r.ovf = (sres < -(full / 2)) || (sres > full / 2 - 1);
      r.zero = (r.s == '0);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   logic exp_valid = 1'b0;
   res_t exp_res   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_valid <= 1'b0;
         exp_res   <= '0;
      end else begin
         exp_valid <= in_valid;
         if (in_valid) exp_res <= model(int'(A), int'(B), SUB);
      end
   end

   always @(negedge clk) begin
      check("cyc_valid", 32'(out_valid), 32'(exp_valid));
      check("cyc_s",     32'(S),         32'(exp_res.s));
      check("cyc_cout",  32'(COUT),      32'(exp_res.cout));
      check("cyc_ovf",   32'(OVF),       32'(exp_res.ovf));
      check("cyc_zero",  32'(ZERO),      32'(exp_res.zero));
   end

   typedef struct {
      int a; int b; bit sub; int s; bit cout; bit ovf; bit zero;
   } vec_t;

   vec_t vecs[10] = '{
      '{10, 3, 1'b0, 13, 1'b0, 1'b0, 1'b0},
      '{10, 3, 1'b1,  7, 1'b1, 1'b1, 1'b0},
      '{ 9, 1, 1'b0, 10, 1'b0, 1'b0, 1'b0},
      '{ 9, 1, 1'b1,  8, 1'b1, 1'b0, 1'b0},
      '{15, 1, 1'b0,  0, 1'b1, 1'b0, 1'b1},
      '{ 0, 1, 1'b1, 15, 1'b0, 1'b0, 1'b0},
      '{ 7, 1, 1'b0,  8, 1'b0, 1'b1, 1'b0},
      '{ 8, 1, 1'b1,  7, 1'b1, 1'b1, 1'b0},
      '{ 5, 0, 1'b1,  5, 1'b1, 1'b0, 1'b0},
      '{ 8, 8, 1'b1,  0, 1'b1, 1'b0, 1'b1}
   };

   task automatic idle();
      in_valid = 1'b0;
      A   = 'x;
      B   = 'x;
      SUB = 1'bx;
   endtask

   task automatic drive(input int a, input int b, input bit sub);
      in_valid = 1'b1;
      A   = WIDTH'(a);
      B   = WIDTH'(b);
      SUB = sub;
   endtask

   initial begin
      res_t m;
      logic [WIDTH-1:0] held;
      int               valid_run;
      rst_n = 1'b1;
      idle();
      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_s",     32'(S),         32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed vectors: pin both the model and the DUT to hand-computed values.
      foreach (vecs[i]) begin
         @(posedge clk); #1 drive(vecs[i].a, vecs[i].b, vecs[i].sub);
         @(posedge clk); #1 idle();
         m = model(vecs[i].a, vecs[i].b, vecs[i].sub);
         check("model_s",    32'(m.s),    32'(vecs[i].s));
         check("model_cout", 32'(m.cout), 32'(vecs[i].cout));
         check("model_ovf",  32'(m.ovf),  32'(vecs[i].ovf));
         check("dir_valid",  32'(out_valid), 32'd1);
         check("dir_s",      32'(S),      32'(vecs[i].s));
         check("dir_cout",   32'(COUT),   32'(vecs[i].cout));
         check("dir_ovf",    32'(OVF),    32'(vecs[i].ovf));
         check("dir_zero",   32'(ZERO),   32'(vecs[i].zero));
      end

      // Three back-to-back results, then an idle cycle holding S.
      @(posedge clk); #1 drive(3, 4, 1'b0);
      @(posedge clk); #1 check("b2b_s0", 32'(S), 32'd7);  drive(3, 4, 1'b1);
      @(posedge clk); #1 check("b2b_s1", 32'(S), 32'd15); drive(12, 4, 1'b0);
      @(posedge clk); #1 check("b2b_s2", 32'(S), 32'd0);  check("b2b_z2", 32'(ZERO), 32'd1);
      valid_run = 0;
      idle();
      @(posedge clk); #1
      check("hold_valid", 32'(out_valid), 32'd0);
      check("hold_s",     32'(S),         32'd0);
      held = S;
      repeat (3) @(posedge clk);
      #1 check("hold_x_s", 32'(S), 32'(held));

      // Exhaustive sweep with random idle gaps.
      for (int sub = 0; sub < 2; sub++)
         for (int a = 0; a < (1 << WIDTH); a++)
            for (int b = 0; b < (1 << WIDTH); b++) begin
               @(posedge clk); #1 drive(a, b, sub[0]);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1 idle();
               end
            end
      @(posedge clk); #1 idle();
      @(posedge clk);

      // Mid-cycle reset with a result in flight.
      #1 drive(15, 1, 1'b0);
      @(posedge clk); #1 drive(7, 1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_s",     32'(S),         32'd0);
      check("mid_rst_cout",  32'(COUT),      32'd0);
      check("mid_rst_ovf",   32'(OVF),       32'd0);
      check("mid_rst_zero",  32'(ZERO),      32'd0);
      @(posedge clk); #1
      check("rst_hold_s", 32'(S), 32'd0);
      idle();
      #1 rst_n = 1'b1;
      @(posedge clk); #1 drive(6, 2, 1'b1);
      @(posedge clk); #1 idle();
      valid_run = valid_run + 32'(out_valid);
      check("post_rst_valid", 32'(valid_run), 32'd1);
      check("post_rst_s",     32'(S),         32'd4);
      repeat (2) @(posedge clk);
      #1 $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
